// File: rtl/fixed_math_pkg.sv
// Shared fixed-point helpers for the multiplier pipeline: round-half-up shift and range fitting.
package fixed_math_pkg;

  localparam int FX_MUL_LATENCY = 3;
  localparam int FX_MAX_W       = 64;

  typedef logic signed [FX_MAX_W-1:0] fx_wide_t;

  typedef struct packed {
    logic     ovf;
    fx_wide_t value;
  } fx_sat_t;

  // Adding half an output LSB before the arithmetic shift gives round-half-up (toward +inf on .5).
  function automatic fx_wide_t fx_round_shift(input fx_wide_t p, input int frac);
    fx_wide_t half;
    if (frac <= 0) begin
      return p;
    end
    half = fx_wide_t'(1) <<< (frac - 1);
    return (p + half) >>> frac;
  endfunction

  function automatic fx_sat_t fx_sat(input fx_wide_t r, input int out_w);
    fx_wide_t max_v;
    fx_wide_t min_v;
    fx_sat_t  res;
    max_v     = (fx_wide_t'(1) <<< (out_w - 1)) - fx_wide_t'(1);
    min_v     = -max_v - fx_wide_t'(1);
    res.ovf   = (r > max_v) || (r < min_v);
    res.value = (r > max_v) ? max_v : ((r < min_v) ? min_v : r);
    return res;
  endfunction

endpackage

// File: rtl/fx_pipe_stage.sv
// Valid/ready register slice; an empty slice accepts even while its consumer is stalled.
module fx_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/fixed_mul_pipe.sv
// Three-slice signed fixed-point multiplier with round-half-up and range fitting.
// Define FIXED_MUL_PIPE_SAT_EN to clamp out-of-range results instead of wrapping them.
module fixed_mul_pipe
  import fixed_math_pkg::*;
#(
  parameter int A_W    = 16,
  parameter int B_W    = 16,
  parameter int FRAC_W = 12,
  parameter int OUT_W  = 16,
  parameter int TAG_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  input  logic        [TAG_W-1:0] in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] c,
  output logic        [TAG_W-1:0] out_tag,
  output logic                    ovf
);

  localparam int P_W  = A_W + B_W;
  localparam int S1_W = A_W + B_W + TAG_W;
  localparam int S2_W = P_W + TAG_W;
  localparam int S3_W = 1 + TAG_W + OUT_W;

  if (FRAC_W >= P_W || OUT_W > P_W || P_W + 1 > FX_MAX_W) begin : g_bad_params
    $error("fixed_mul_pipe: illegal FRAC_W/OUT_W for the given operand widths");
  end

  logic            s1_valid, s2_valid, s2_ready, s3_ready;
  logic [S1_W-1:0] s1_data;
  logic [S2_W-1:0] s2_data;
  logic [S3_W-1:0] s3_data;

  fx_pipe_stage #(.W(S1_W)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data({in_tag, a, b}),
    .out_valid(s1_valid), .out_ready(s2_ready), .out_data(s1_data)
  );

  logic signed [A_W-1:0]   s1_a;
  logic signed [B_W-1:0]   s1_b;
  logic        [TAG_W-1:0] s1_tag;
  logic signed [P_W-1:0]   prod;

  assign s1_tag = s1_data[S1_W-1 -: TAG_W];
  assign s1_a   = s1_data[P_W-1 -: A_W];
  assign s1_b   = s1_data[B_W-1:0];
  // Both operands are sign-extended to the full product width; the product cannot overflow it.
  assign prod   = P_W'(s1_a) * P_W'(s1_b);

  fx_pipe_stage #(.W(S2_W)) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s1_valid), .in_ready(s2_ready), .in_data({s1_tag, prod}),
    .out_valid(s2_valid), .out_ready(s3_ready), .out_data(s2_data)
  );

  logic signed [P_W-1:0]   s2_prod;
  logic        [TAG_W-1:0] s2_tag;
  fx_wide_t                r_wide;
  fx_sat_t                 sat;
  logic        [OUT_W-1:0] c_val;
  logic                    unused_fit_bits;

  assign s2_tag  = s2_data[S2_W-1 -: TAG_W];
  assign s2_prod = s2_data[P_W-1:0];
  assign r_wide  = fx_round_shift(fx_wide_t'(s2_prod), FRAC_W);
  assign sat     = fx_sat(r_wide, OUT_W);

`ifdef FIXED_MUL_PIPE_SAT_EN
  assign c_val = sat.value[OUT_W-1:0];
`else
  assign c_val = r_wide[OUT_W-1:0];
`endif

  assign unused_fit_bits = ^{r_wide, sat};

  fx_pipe_stage #(.W(S3_W)) u_s3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s2_valid), .in_ready(s3_ready), .in_data({sat.ovf, s2_tag, c_val}),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(s3_data)
  );

  assign ovf     = s3_data[S3_W-1];
  assign out_tag = s3_data[OUT_W +: TAG_W];
  assign c       = s3_data[OUT_W-1:0];

endmodule

// File: tb/tb_fixed_mul_pipe.sv
// Randomised self-checking bench for fixed_mul_pipe against a plain-arithmetic reference model.
module tb_fixed_mul_pipe;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] a = '0;
  logic signed [15:0] b = '0;
  logic        [0:0]  in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] c;
  logic        [0:0]  out_tag;
  logic               ovf;

  fixed_mul_pipe #(
    .A_W(16), .B_W(16), .FRAC_W(12), .OUT_W(16), .TAG_W(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .out_tag(out_tag), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint c;
    int     tag;
    int     ovf;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     failures = 0;
  bit     acc_f, del_f, rdy_s;
  longint last_c;
  int     last_tag, last_ovf, del_cnt, cyc;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact product, add half of 2^-12, floor-divide, then fit to 16 bits.
  function automatic exp_t model(input longint av, input longint bv, input int tg);
    exp_t   e;
    longint num, q;
    num = av * bv + 2048;
    q   = num / 4096;
    if ((num % 4096) != 0 && num < 0) q = q - 1;
    e.ovf = (q > 32767 || q < -32768) ? 1 : 0;
`ifdef FIXED_MUL_PIPE_SAT_EN
    e.c = (q > 32767) ? 32767 : ((q < -32768) ? -32768 : q);
`else
    begin
      longint m;
      m   = ((q % 65536) + 65536) % 65536;
      e.c = (m >= 32768) ? m - 65536 : m;
    end
`endif
    e.tag = tg;
    return e;
  endfunction

  // One clock cycle: entered and left at a falling edge; observes just after it.
  task automatic cycle();
    exp_t e;
    #1;
    rdy_s = in_ready;
    acc_f = in_valid && in_ready;
    del_f = out_valid && out_ready;
    if (acc_f) exp_q.push_back(model(a, b, int'(in_tag)));
    if (out_valid && !out_ready && exp_q.size() > 0) check("stall_hold_c", c, exp_q[0].c);
    if (del_f) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_c", c, e.c);
        check("out_tag", out_tag, e.tag);
        check("out_ovf", ovf, e.ovf);
      end
      last_c   = c;
      last_tag = int'(out_tag);
      last_ovf = int'(ovf);
      del_cnt++;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_one(input string nm, input int av, input int bv, input int tg,
                          input longint exp_c, input int exp_ovf);
    int lat;
    bit got;
    out_ready = 1'b1;
    a = 16'(av); b = 16'(bv); in_tag = 1'(tg); in_valid = 1'b1;
    cycle();
    check({nm, "_accept"}, acc_f, 1);
    in_valid = 1'b0;
    lat = 0; got = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      cycle();
      if (del_f) begin got = 1; lat = i; end
    end
    check({nm, "_latency"}, lat, 3);
    check({nm, "_c"}, last_c, exp_c);
    check({nm, "_tag"}, last_tag, tg);
    check({nm, "_ovf"}, last_ovf, exp_ovf);
    $display("txn %s a=%0d b=%0d -> c=%0d ovf=%0d lat=%0d", nm, av, bv, last_c, last_ovf, lat);
  endtask

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int ia[5], ib[5], idx, pops[5], npop;
    cyc = 0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_c", c, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send_one("basic", 2048, 2048, 1, 1024, 0);
    send_one("rnd_pos_half", 1, 2048, 0, 1, 0);
    send_one("rnd_neg_half", -1, 2048, 1, 0, 0);
    send_one("rnd_neg_1p5", -1, 6144, 0, -1, 0);
`ifdef FIXED_MUL_PIPE_SAT_EN
    send_one("ovf_pos", 32767, 32767, 1, 32767, 1);
    send_one("ovf_neg", -32768, 32767, 0, -32768, 1);
`else
    send_one("ovf_pos", 32767, 32767, 1, -16, 1);
    send_one("ovf_neg", -32768, 32767, 0, 8, 1);
`endif

    // Backpressure: five items offered while the output is stalled.
    for (int i = 0; i < 5; i++) begin
      ia[i] = int'($urandom_range(0, 65535)) - 32768;
      ib[i] = int'($urandom_range(0, 8191)) - 4096;
    end
    out_ready = 1'b0; idx = 0; del_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      a = 16'(ia[idx < 5 ? idx : 4]); b = 16'(ib[idx < 5 ? idx : 4]); in_tag = 1'(idx); in_valid = 1'b1;
      cycle();
      if (acc_f) idx++;
    end
    check("bp_accepted", idx, 3);
    check("bp_in_ready", rdy_s, 0);
    check("bp_no_output", del_cnt, 0);
    out_ready = 1'b1; npop = 0;
    for (int i = 0; i < 20 && (idx < 5 || exp_q.size() > 0); i++) begin
      if (idx < 5) begin
        a = 16'(ia[idx]); b = 16'(ib[idx]); in_tag = 1'(idx); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      if (acc_f) idx++;
      if (del_f && npop < 5) begin pops[npop] = cyc; npop++; end
    end
    in_valid = 1'b0;
    check("bp_total_out", npop, 5);
    check("bp_consecutive_1", pops[1] - pops[0], 1);
    check("bp_consecutive_2", pops[2] - pops[1], 1);
    $display("txn backpressure accepted=%0d delivered=%0d", idx, npop);

    // Streaming with random valid and random downstream ready.
    idx = 0; del_cnt = 0;
    for (int i = 0; i < 3000 && (idx < 100 || exp_q.size() > 0); i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (idx < 100) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = 16'($urandom); b = 16'($urandom); in_tag = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      if (acc_f) idx++;
      if (del_f) $display("txn stream #%0d c=%0d tag=%0d ovf=%0d", del_cnt, last_c, last_tag, last_ovf);
    end
    in_valid = 1'b0;
    check("stream_accepted", idx, 100);
    check("stream_delivered", del_cnt, 100);
    check("stream_drained", exp_q.size(), 0);

    // Reset with three items in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); in_tag = 1'b1; in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    #1;
    check("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_c", c, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_one("post_rst", 2048, 4096, 1, 2048, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
